div_sequencer: RTL and testbench
================================

Name: div_sequencer

Overview:
- Multi-cycle M-extension divide unit controller: accepts DIV/DIVU/REM/REMU from the execute stage over a valid/ready handshake.
- Sequences a 32-bit restoring iteration core, performs operand sign conditioning and result sign fix-up.
- Resolves the RISC-V special cases (divide-by-zero, signed overflow) without iterating.
- Returns one 32-bit result with its destination tag to writeback; sits beside the ALU and stalls issue while busy.

Parameters:
- XLEN, 32, operand/result width; equals REG_SIZE.
- TAG_W, 5, destination register tag width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- flush  in  1  pipeline kill; abandons any in-flight op.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept.
- req_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0]).
- req_rs1  in  XLEN  dividend.
- req_rs2  in  XLEN  divisor.
- req_tag  in  TAG_W  destination tag.
- resp_valid  out  1  result present.
- resp_ready  in  1  writeback accepts result.
- resp_result  out  XLEN  quotient or remainder per op.
- resp_tag  out  TAG_W  tag of result.
- busy  out  1  state != IDLE.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - Reset values: state IDLE; req_ready=1; resp_valid=0; resp_result=0; resp_tag=0; busy=0; counter=0.
- Handshake:
  - req_ready=1 only in IDLE with flush=0.
  - Accept on edge with req_valid&req_ready; capture op, operands, tag.
  - Response held stable while resp_valid=1 and resp_ready=0.
  - Response retires on resp_valid&resp_ready; state goes to IDLE.
  - No accept on the retiring edge: minimum one IDLE cycle between ops.
- States: IDLE, PREP, ITER, FIXUP, DONE.
  - IDLE -> PREP on accept.
  - PREP: compute magnitudes. Signed op: |rs1|, |rs2| (two's complement); unsigned op: raw. Record neg_q = rs1[31]^rs2[31] and neg_r = rs1[31] (signed ops only).
  - PREP -> DONE if rs2==0 or (signed op and rs1==0x80000000 and rs2==0xFFFFFFFF); otherwise PREP -> ITER with counter=0.
  - ITER: one restoring step per edge.
    - 64-bit {rem,quo} shift left one bit.
    - 33-bit trial subtract rem - divisor; if non-negative, keep the difference and set the quotient LSB to 1.
    - counter 5 bits, increments each step; after 32 steps (counter wraps 31->0) -> FIXUP.
  - FIXUP: quotient negated if neg_q; remainder negated if neg_r; select by op[1]; -> DONE.
  - DONE: resp_valid=1 until retired.
- Latency, counting edges after the accepting edge: normal ops resp_valid high after 34 edges (PREP 1 + ITER 32 + FIXUP 1); special cases after 1 edge.
- Special-case results:
  - x/0: DIV and DIVU return 0xFFFFFFFF; REM and REMU return rs1.
  - Overflow: DIV returns 0x80000000; REM returns 0.
- Flush:
  - Any state -> IDLE on the next edge; resp_valid drops; result discarded.
  - flush overrides a simultaneous accept and a simultaneous retire (result is lost, no retire counted).
- Reset mid-operation behaves identically to flush plus counter clear.
- Operands that change after the accepting edge have no effect.

Optional Feature:
- DIV_RESULT_CACHE_EN: stores rs1, rs2, signedness, quotient and remainder of the last normally completed op.
  - A new request with equal rs1, rs2 and signedness (op[0]) hits: IDLE -> DONE in 1 edge, result selected by op[1]. This covers the DIV-then-REM pair.
  - Cache is invalidated by reset and by flush during ITER/FIXUP; it is never written by special-case ops.
  - Without the macro: no cache storage; every op follows PREP.

Decomposition:
- Shared package div_pkg: XLEN constant, div_op_e enum (DIV, DIVU, REM, REMU), div_state_e enum, INT_MIN constant 0x80000000, ALL_ONES constant.
- One sub-module div_iter_core: shift/subtract datapath with load, step, magnitudes in, quotient/remainder out.
- div_sequencer holds the FSM, counter, sign logic, special cases and cache.

Test Plan:
- DIV 100 / -7 -> resp_result 0xFFFFFFF2 (-14), resp_valid 34 edges after accept; REM same operands -> 2.
- DIVU 0xFFFFFFFF / 0x10 -> 0x0FFFFFFF; REMU -> 0xF; check tag echoed.
- DIV 5 / 0 -> 0xFFFFFFFF and REM 5 / 0 -> 5, each after 1 edge; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
- resp_ready held 0 for 10 cycles in DONE -> result and tag stable, req_ready=0; then one retire cycle -> IDLE, next request accepted.
- flush asserted at ITER step 15 together with req_valid -> IDLE next edge, no resp_valid, request not accepted; following op correct.
- With DIV_RESULT_CACHE_EN: DIV -20 / 3 (-> -6) then REM -20 / 3 -> -2 after 1 edge; REMU same operands -> misses (signedness differs), full 34-edge latency.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the M-extension divide sequencer: operand width,
// operation and state encodings, and the RISC-V special-case constants.
package div_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] INT_MIN  = 32'h8000_0000;
    localparam logic [XLEN-1:0] ALL_ONES = 32'hFFFF_FFFF;

    // Encoding follows funct3[1:0]: bit 0 = unsigned, bit 1 = remainder.
    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PREP  = 3'd1,
        ITER  = 3'd2,
        FIXUP = 3'd3,
        DONE  = 3'd4
    } div_state_e;

endpackage

// File: rtl/div_sequencer_if.sv
// Request/response handshake between the execute stage (master) and the
// divide sequencer (slave).
interface div_sequencer_if #(
    parameter int TAG_W = 5
);
    logic                     req_valid;
    logic                     req_ready;
    logic [1:0]               req_op;
    logic [div_pkg::XLEN-1:0] req_rs1;
    logic [div_pkg::XLEN-1:0] req_rs2;
    logic [TAG_W-1:0]         req_tag;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [div_pkg::XLEN-1:0] resp_result;
    logic [TAG_W-1:0]         resp_tag;

    modport master (
        output req_valid, req_op, req_rs1, req_rs2, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_tag
    );

    modport slave (
        input  req_valid, req_op, req_rs1, req_rs2, req_tag, resp_ready,
        output req_ready, resp_valid, resp_result, resp_tag
    );
endinterface

// File: rtl/div_iter_core.sv
// Restoring shift/subtract divide core on unsigned magnitudes. load seeds the
// core; each step cycle retires one quotient bit, MSB first.
module div_iter_core
    import div_pkg::*;
(
    input  logic            clk,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quo,
    output logic [XLEN-1:0] rem
);
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] dvsr_q;
    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] diff;

    // The shifted partial remainder can reach 33 bits; one extra bit keeps
    // the borrow of the trial subtract unambiguous.
    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign diff    = {1'b0, shifted} - {2'b00, dvsr_q};

    // Seed on load, otherwise one restoring step per enabled cycle.
    always_ff @(posedge clk) begin
        if (load) begin
            rem_q  <= '0;
            quo_q  <= dividend;
            dvsr_q <= divisor;
        end else if (step) begin
            if (!diff[XLEN+1]) begin
                rem_q <= diff[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_q <= shifted[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b0};
            end
        end
    end

    assign quo = quo_q;
    assign rem = rem_q;

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU controller: operand sign conditioning,
// special-case resolution, 32-step iteration and result sign fix-up.
// Optional build macro DIV_RESULT_CACHE_EN adds a last-result cache so a
// matching follow-up request (e.g. REM after DIV) completes in one edge.
module div_sequencer
    import div_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    div_sequencer_if.slave bus,
    output logic           busy
);
    div_state_e       state_q, state_d;
    div_op_e          op_q;
    logic [XLEN-1:0]  rs1_q, rs2_q, result_q;
    logic [TAG_W-1:0] tag_q;
    logic [4:0]       count_q;
    logic             neg_q_q, neg_r_q;
    logic             core_load, core_step;
    logic [XLEN-1:0]  core_quo, core_rem, mag1, mag2;
    logic [XLEN-1:0]  fix_q, fix_r, special_res, hit_res;
    logic             is_signed, div_zero, overflow, special, cache_hit, take_req;

    function automatic logic [XLEN-1:0] cond_neg(input logic neg, input logic [XLEN-1:0] v);
        return neg ? ({XLEN{1'b0}} - v) : v;
    endfunction

    assign is_signed   = ~op_q[0];
    assign mag1        = cond_neg(is_signed & rs1_q[XLEN-1], rs1_q);
    assign mag2        = cond_neg(is_signed & rs2_q[XLEN-1], rs2_q);
    assign div_zero    = (rs2_q == '0);
    assign overflow    = is_signed && (rs1_q == INT_MIN) && (rs2_q == ALL_ONES);
    assign special     = div_zero || overflow;
    assign special_res = div_zero ? (op_q[1] ? rs1_q : ALL_ONES)
                                  : (op_q[1] ? '0    : INT_MIN);
    assign fix_q       = cond_neg(neg_q_q, core_quo);
    assign fix_r       = cond_neg(neg_r_q, core_rem);
    assign take_req    = (state_q == IDLE) && bus.req_valid && !flush;

    div_iter_core u_core (
        .clk      (clk),
        .load     (core_load),
        .step     (core_step),
        .dividend (mag1),
        .divisor  (mag2),
        .quo      (core_quo),
        .rem      (core_rem)
    );

`ifdef DIV_RESULT_CACHE_EN
    logic            c_vld, c_uns;
    logic [XLEN-1:0] c_rs1, c_rs2, c_quo, c_rem;

    assign cache_hit = c_vld && (bus.req_rs1 == c_rs1) && (bus.req_rs2 == c_rs2)
                       && (bus.req_op[0] == c_uns);
    assign hit_res   = bus.req_op[1] ? c_rem : c_quo;

    // Cache is valid only after a normal completion; a kill mid-iteration drops it.
    always_ff @(posedge clk) begin
        if (reset) begin
            c_vld <= 1'b0;
        end else if (flush && (state_q == ITER || state_q == FIXUP)) begin
            c_vld <= 1'b0;
        end else if (state_q == FIXUP) begin
            c_vld <= 1'b1;
        end
    end

    // Record operands and both signed-corrected results of the finishing op.
    always_ff @(posedge clk) begin
        if (state_q == FIXUP && !flush) begin
            c_rs1 <= rs1_q;
            c_rs2 <= rs2_q;
            c_uns <= op_q[0];
            c_quo <= fix_q;
            c_rem <= fix_r;
        end
    end
`else
    assign cache_hit = 1'b0;
    assign hit_res   = '0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and core control; flush wins over every other transition.
    always_comb begin
        state_d   = state_q;
        core_load = 1'b0;
        core_step = 1'b0;
        unique case (state_q)
            IDLE:    if (bus.req_valid) state_d = cache_hit ? DONE : PREP;
            PREP: begin
                core_load = 1'b1;
                state_d   = special ? DONE : ITER;
            end
            ITER: begin
                core_step = 1'b1;
                if (count_q == 5'd31) state_d = FIXUP;
            end
            FIXUP:   state_d = DONE;
            DONE:    if (bus.resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // Step counter and the registered response.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            result_q <= '0;
            tag_q    <= '0;
        end else begin
            if (take_req) begin
                tag_q <= bus.req_tag;
                if (cache_hit) result_q <= hit_res;
            end
            if (state_q == PREP) begin
                count_q <= '0;
                if (special) result_q <= special_res;
            end
            if (state_q == ITER)  count_q  <= count_q + 5'd1;
            if (state_q == FIXUP) result_q <= op_q[1] ? fix_r : fix_q;
        end
    end

    // Operand capture on accept; result signs fixed while preparing.
    always_ff @(posedge clk) begin
        if (take_req) begin
            op_q  <= div_op_e'(bus.req_op);
            rs1_q <= bus.req_rs1;
            rs2_q <= bus.req_rs2;
        end
        if (state_q == PREP) begin
            neg_q_q <= is_signed & (rs1_q[XLEN-1] ^ rs2_q[XLEN-1]);
            neg_r_q <= is_signed & rs1_q[XLEN-1];
        end
    end

    assign bus.req_ready   = (state_q == IDLE) && !flush;
    assign bus.resp_valid  = (state_q == DONE);
    assign bus.resp_result = result_q;
    assign bus.resp_tag    = tag_q;
    assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: directed vector table, multi-cycle corner
// sequences (backpressure, flush, reset mid-op) and random operations
// checked against an arithmetic reference model.
module tb_div_sequencer;
    localparam int TAG_W = 5;

    logic clk = 1'b0;
    logic reset, flush, busy;
    int   checks = 0;
    int   errors = 0;

    // Reference view of the result cache (only consulted when the macro is set).
    bit          m_vld;
    logic [31:0] m_a, m_b;
    logic        m_uns;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t        vecs[18];
    logic [1:0]  r_op;
    logic [31:0] r_a, r_b, pa, pb, hold_res;
    int          r_sel, r_lat, n, bad;

    div_sequencer_if #(.TAG_W(TAG_W)) bus();

    div_sequencer #(.TAG_W(TAG_W)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // RISC-V divide semantics from plain integer arithmetic.
    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'h0 : 32'h8000_0000;
        if (!op[0]) return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        return op[1] ? a % b : a / b;
    endfunction

    // Drive one request and let it be accepted; operands are scrambled afterwards.
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] tag);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_rs1   = a;
        bus.req_rs2   = b;
        bus.req_tag   = tag;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_rs1   = $urandom;
        bus.req_rs2   = $urandom;
        bus.req_op    = 2'($urandom);
        bus.req_tag   = 5'($urandom);
    endtask

    // Count edges after the accepting edge until resp_valid (bounded).
    task automatic wait_resp(output int edges);
        edges = 0;
        while (!bus.resp_valid && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input logic [31:0] exp_res,
                          input int nominal_lat, input string name);
        int edges, exp_lat;
        bit hit;
        hit = 1'b0;
`ifdef DIV_RESULT_CACHE_EN
        hit = m_vld && (a == m_a) && (b == m_b) && (op[0] == m_uns);
`endif
        // A cache hit resolves on the accepting edge itself.
        exp_lat = hit ? 0 : nominal_lat;
        check({name, " req_ready"}, 32'(bus.req_ready), 32'd1);
        start_op(op, a, b, tag);
        wait_resp(edges);
        check({name, " latency"}, 32'(edges), 32'(exp_lat));
        check({name, " result"}, bus.resp_result, exp_res);
        check({name, " tag"}, 32'(bus.resp_tag), 32'(tag));
        if (!hit && nominal_lat == 34) begin
            m_vld = 1'b1;
            m_a   = a;
            m_b   = b;
            m_uns = op[0];
        end
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_op     = 2'b00;
        bus.req_rs1    = '0;
        bus.req_rs2    = '0;
        bus.req_tag    = '0;
        bus.resp_ready = 1'b1;
        m_vld = 1'b0;
        m_a   = '0;
        m_b   = '0;
        m_uns = 1'b0;
        pa = 32'd1;
        pb = 32'd1;

        vecs[0]  = '{2'b00, 32'd100,       32'hFFFF_FFF9, 5'h03, 32'hFFFF_FFF2, 34};
        vecs[1]  = '{2'b10, 32'd100,       32'hFFFF_FFF9, 5'h04, 32'h0000_0002, 34};
        vecs[2]  = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0010, 5'h1A, 32'h0FFF_FFFF, 34};
        vecs[3]  = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 5'h1B, 32'h0000_000F, 34};
        vecs[4]  = '{2'b00, 32'd5,         32'h0,         5'h07, 32'hFFFF_FFFF, 1};
        vecs[5]  = '{2'b10, 32'd5,         32'h0,         5'h08, 32'h0000_0005, 1};
        vecs[6]  = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'h09, 32'h8000_0000, 1};
        vecs[7]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'h0A, 32'h0000_0000, 1};
        vecs[8]  = '{2'b01, 32'd7,         32'h0,         5'h0B, 32'hFFFF_FFFF, 1};
        vecs[9]  = '{2'b11, 32'd7,         32'h0,         5'h0C, 32'h0000_0007, 1};
        vecs[10] = '{2'b00, 32'hFFFF_FFEC, 32'd3,         5'h0D, 32'hFFFF_FFFA, 34};
        vecs[11] = '{2'b10, 32'hFFFF_FFEC, 32'd3,         5'h0E, 32'hFFFF_FFFE, 34};
        vecs[12] = '{2'b11, 32'hFFFF_FFEC, 32'd3,         5'h0F, 32'h0000_0002, 34};
        vecs[13] = '{2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'h10, 32'h0000_0000, 34};
        vecs[14] = '{2'b00, 32'h8000_0000, 32'd1,         5'h11, 32'h8000_0000, 34};
        vecs[15] = '{2'b10, 32'd7,         32'hFFFF_FFFD, 5'h12, 32'h0000_0001, 34};
        vecs[16] = '{2'b00, 32'hFFFF_FFF9, 32'hFFFF_FFFD, 5'h13, 32'h0000_0002, 34};
        vecs[17] = '{2'b01, 32'd0,         32'd5,         5'h14, 32'h0000_0000, 34};

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check("reset req_ready",   32'(bus.req_ready),  32'd1);
        check("reset resp_valid",  32'(bus.resp_valid), 32'd0);
        check("reset resp_result", bus.resp_result,     32'd0);
        check("reset resp_tag",    32'(bus.resp_tag),   32'd0);
        check("reset busy",        32'(busy),           32'd0);

        for (int i = 0; i < 18; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].res, vecs[i].lat,
                   $sformatf("vec%0d", i));

        // Backpressure: response must hold while resp_ready is low.
        bus.resp_ready = 1'b0;
        start_op(2'b00, 32'd1000, 32'd7, 5'h15);
        wait_resp(n);
        check("bp latency", 32'(n), 32'd34);
        check("bp result", bus.resp_result, 32'd142);
        m_vld = 1'b1; m_a = 32'd1000; m_b = 32'd7; m_uns = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b01;
        bus.req_rs1   = 32'd1;
        bus.req_rs2   = 32'd1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp hold valid",  32'(bus.resp_valid), 32'd1);
            check("bp hold result", bus.resp_result,     32'd142);
            check("bp hold tag",    32'(bus.resp_tag),   32'h15);
            check("bp hold ready",  32'(bus.req_ready),  32'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp retire valid", 32'(bus.resp_valid), 32'd0);
        check("bp retire busy",  32'(busy),           32'd0);
        check("bp retire ready", 32'(bus.req_ready),  32'd1);
        bus.req_valid = 1'b0;
        run_op(2'b10, 32'd1000, 32'd7, 5'h16, 32'd6, 34, "bp next");

        // Flush during iteration, colliding with a new request.
        start_op(2'b00, 32'd12345, 32'd17, 5'h17);
        repeat (15) @(posedge clk);
        #1;
        flush = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b01;
        bus.req_rs1   = 32'd9;
        bus.req_rs2   = 32'd3;
        check("flush req_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        bus.req_valid = 1'b0;
        check("flush busy",       32'(busy),           32'd0);
        check("flush resp_valid", 32'(bus.resp_valid), 32'd0);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.resp_valid || busy) bad++;
        end
        check("flush stays idle", 32'(bad), 32'd0);
        m_vld = 1'b0;
        run_op(2'b00, 32'd12345, 32'd17, 5'h18, 32'd726, 34, "flush next");

        // Reset in the middle of an operation.
        start_op(2'b11, 32'hDEAD_BEEF, 32'h0000_1234, 5'h19);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midreset resp_valid",  32'(bus.resp_valid), 32'd0);
        check("midreset busy",        32'(busy),           32'd0);
        check("midreset req_ready",   32'(bus.req_ready),  32'd1);
        check("midreset resp_result", bus.resp_result,     32'd0);
        check("midreset resp_tag",    32'(bus.resp_tag),   32'd0);
        m_vld = 1'b0;
        run_op(2'b11, 32'hDEAD_BEEF, 32'h0000_1234, 5'h1C,
               ref_div(2'b11, 32'hDEAD_BEEF, 32'h0000_1234), 34, "midreset next");

        // Random operations, biased towards special and repeated operands.
        for (int i = 0; i < 40; i++) begin
            r_op  = 2'($urandom);
            r_sel = $urandom_range(0, 9);
            r_a   = $urandom;
            r_b   = $urandom;
            case (r_sel)
                0:       r_b = 32'h0;
                1:       begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
                2, 3:    begin r_a = pa; r_b = pb; end
                4:       r_b = 32'($urandom_range(1, 50));
                5:       r_b = ~32'($urandom_range(0, 49));
                default: ;
            endcase
            r_lat = (r_b == 32'h0 || (!r_op[0] && r_a == 32'h8000_0000 && r_b == 32'hFFFF_FFFF))
                    ? 1 : 34;
            run_op(r_op, r_a, r_b, 5'($urandom), ref_div(r_op, r_a, r_b), r_lat,
                   $sformatf("rnd%0d", i));
            if (r_lat == 34) begin
                pa = r_a;
                pb = r_b;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
